// File: rtl/boot_mem_arbiter.sv
// boot_mem_arbiter: registered boot sequencer and RAM bus arbiter.
// The loader owns basic_ram until it reports finished. The bus then drains,
// the CPU is held in reset for a short window, and finally the CPU owns the
// bus until the next rst.
// Optional feature: define BOOT_ARB_TIMEOUT_EN to force boot after
// TIMEOUT_CYCLES LOAD cycles without ld_finished. This also sets boot_timeout.
module boot_mem_arbiter #(
  parameter int RST_HOLD       = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_wdata,
  output logic [31:0]      ld_rdata,
  input  logic             ld_cs,
  input  logic             ld_we,
  input  logic             ld_oe,
  input  logic             ld_finished,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  input  logic             cpu_cs,
  input  logic             cpu_we,
  input  logic             cpu_oe,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  output logic             ram_cs,
  output logic             ram_we,
  output logic             ram_oe,
  input  logic             ram_mem_done,
  output logic             cpu_rst,
  output logic [1:0]       boot_state,
  output logic [CNT_W-1:0] ld_words,
  output logic             early_access,
  output logic             boot_timeout
);

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    DRAIN = 2'b01,
    HOLD  = 2'b10,
    RUN   = 2'b11
  } state_t;

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               cpu_rst_q;
  logic [CNT_W-1:0]   ld_words_q;
  logic               early_q;
  logic               force_boot;
  logic               ld_write_done;

  assign ld_write_done = ld_cs & ld_we & ram_mem_done;

`ifdef BOOT_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  // The current LOAD cycle is the TIMEOUT_CYCLES-th one and the loader is still not finished.
  assign force_boot = (state_q == LOAD) && !ld_finished &&
                      (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Count LOAD cycles and remember whether boot had to be forced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == LOAD) to_cnt_q <= to_cnt_q + TO_W'(1);
      if (force_boot)      timeout_q <= 1'b1;
    end
  end

  assign boot_timeout = timeout_q;
`else
  assign force_boot   = 1'b0;
  assign boot_timeout = 1'b0;
`endif

  // Next-state logic for the boot sequence and the reset-hold countdown.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      LOAD: begin
        if (ld_finished || force_boot) state_d = DRAIN;
      end
      DRAIN: begin
        // Hand over only once the loader has no transaction in flight.
        if (!ld_cs) begin
          if (RST_HOLD == 0) begin
            state_d = RUN;
          end else begin
            state_d = HOLD;
            hold_d  = HOLD_W'(RST_HOLD - 1);
          end
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = RUN;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  // State register, CPU reset, and sticky status bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      hold_q     <= '0;
      cpu_rst_q  <= 1'b1;
      ld_words_q <= '0;
      early_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cpu_rst_q <= (state_d != RUN);
      if ((state_q == LOAD || state_q == DRAIN) && ld_write_done && (ld_words_q != '1))
        ld_words_q <= ld_words_q + CNT_W'(1);
      if (cpu_cs && (state_q != RUN))
        early_q <= 1'b1;
    end
  end

  // Route the owner's request to RAM and RAM data back to the owner only.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    ld_rdata  = '0;
    cpu_rdata = '0;
    unique case (state_q)
      LOAD, DRAIN: begin
        ram_addr  = ld_addr;
        ram_wdata = ld_wdata;
        ram_cs    = ld_cs;
        ram_we    = ld_we;
        ram_oe    = ld_oe;
        ld_rdata  = ram_rdata;
      end
      RUN: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_cs    = cpu_cs;
        ram_we    = cpu_we;
        ram_oe    = cpu_oe;
        cpu_rdata = ram_rdata;
      end
      default: begin
        ram_cs = 1'b0;
      end
    endcase
  end

  assign cpu_rst      = cpu_rst_q;
  assign boot_state   = state_q;
  assign ld_words     = ld_words_q;
  assign early_access = early_q;

endmodule
